// File: rtl/huc6270_pkg.sv
// Shared HuC6270 VDC definitions.
// Register selects, increment steps and read-port FSM states.
package huc6270_pkg;

  localparam logic [1:0] REG_STATUS  = 2'd0;
  localparam logic [1:0] REG_RSVD    = 2'd1;
  localparam logic [1:0] REG_DATA_LO = 2'd2;
  localparam logic [1:0] REG_DATA_HI = 2'd3;

  typedef enum logic [1:0] {
    INCR_1,
    INCR_32,
    INCR_64,
    INCR_128
  } incr_e;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_REQ,
    RD_WAIT
  } rd_state_e;

  function automatic logic [7:0] incr_step(incr_e sel);
    logic [7:0] s;
    s = 8'd1;
    unique case (sel)
      INCR_1:   s = 8'd1;
      INCR_32:  s = 8'd32;
      INCR_64:  s = 8'd64;
      INCR_128: s = 8'd128;
      default:  s = 8'd1;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/vdc_read_port_if.sv
// VRAM read request/grant bus between the read port and the arbiter.
// master: req/addr out, gnt/rvalid/rdata in; slave is the mirror.
interface vdc_read_port_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              vram_req;
  logic [ADDR_W-1:0] vram_addr;
  logic              vram_gnt;
  logic              vram_rvalid;
  logic [DATA_W-1:0] vram_rdata;

  modport master (
    output vram_req,
    output vram_addr,
    input  vram_gnt,
    input  vram_rvalid,
    input  vram_rdata
  );

  modport slave (
    input  vram_req,
    input  vram_addr,
    output vram_gnt,
    output vram_rvalid,
    output vram_rdata
  );
endinterface

// File: rtl/vdc_read_port_reg.sv
// Load-enabled register with async active-high reset to zero.
// Ports: clock, reset, en (load), d (next), q (held value).
module vdc_read_port_reg #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset)   q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/vdc_read_port.sv
// HuC6270 CPU read port: MARR, VRAM read latch and prefetch FSM.
// Ports: clock/reset, CPU strobe+select, MARR load, vram bus, cpu_dout, busy.
module vdc_read_port
  import huc6270_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_rd,
  input  logic [1:0]        cpu_a,
  input  logic              marr_ld,
  input  logic [ADDR_W-1:0] marr_val,
  input  logic [1:0]        incr_sel,
  output logic [7:0]        cpu_dout,
  output logic              busy,
  vdc_read_port_if.master   vram
);

  rd_state_e state, state_n;
  logic pending, pending_n;
  logic take, lat_ld;
  logic hi_rd, trig;
  logic [ADDR_W-1:0] marr, marr_d, addr_q;
  logic [DATA_W-1:0] latch;
  logic [7:0] dout_d;

  assign hi_rd = cpu_rd & (cpu_a == REG_DATA_HI);
  assign trig  = marr_ld | hi_rd;

  // marr_ld takes priority over the high-byte increment
  assign marr_d = marr_ld ? marr_val
                : marr + ADDR_W'(incr_step(incr_e'(incr_sel)));

  vdc_read_port_reg #(.W(ADDR_W)) u_marr (
    .clock (clock),
    .reset (reset),
    .en    (trig),
    .d     (marr_d),
    .q     (marr)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= RD_IDLE;
      pending <= 1'b0;
    end else begin
      state   <= state_n;
      pending <= pending_n;
    end
  end

  // take: issue a request now, sampling the current MARR
  always_comb begin
    state_n = state;
    take    = 1'b0;
    lat_ld  = 1'b0;
    unique case (state)
      RD_IDLE: begin
        if (pending) begin
          state_n = RD_REQ;
          take    = 1'b1;
        end
      end
      RD_REQ: begin
        if (vram.vram_gnt) state_n = RD_WAIT;
      end
      RD_WAIT: begin
        if (vram.vram_rvalid) begin
          lat_ld = 1'b1;
          if (pending) begin
            state_n = RD_REQ;
            take    = 1'b1;
          end else begin
            state_n = RD_IDLE;
          end
        end
      end
      default: state_n = RD_IDLE;
    endcase
  end

  // a trigger in the same cycle as a take re-arms for the newer MARR
  assign pending_n = trig | (pending & ~take);

  vdc_read_port_reg #(.W(ADDR_W)) u_addr (
    .clock (clock),
    .reset (reset),
    .en    (take),
    .d     (marr),
    .q     (addr_q)
  );

  vdc_read_port_reg #(.W(DATA_W)) u_latch (
    .clock (clock),
    .reset (reset),
    .en    (lat_ld),
    .d     (vram.vram_rdata),
    .q     (latch)
  );

  assign busy           = pending | (state != RD_IDLE);
  assign vram.vram_req  = (state == RD_REQ);
  assign vram.vram_addr = addr_q;

  always_comb begin
    dout_d = 8'h00;
    unique case (1'b1)
      (cpu_a == REG_STATUS):  dout_d = {busy, 7'b0};
      (cpu_a == REG_RSVD):    dout_d = 8'h00;
      (cpu_a == REG_DATA_LO): dout_d = latch[7:0];
      (cpu_a == REG_DATA_HI): dout_d = latch[15:8];
      default:                dout_d = 8'h00;
    endcase
  end

  vdc_read_port_reg #(.W(8)) u_dout (
    .clock (clock),
    .reset (reset),
    .en    (cpu_rd),
    .d     (dout_d),
    .q     (cpu_dout)
  );

endmodule

// File: tb/tb_vdc_read_port.sv
// Directed bench for vdc_read_port.
// Drives CPU and arbiter sides, checks outputs 1 time unit after each edge.
module tb_vdc_read_port;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_rd = 1'b0;
  logic [1:0]  cpu_a = 2'd0;
  logic        marr_ld = 1'b0;
  logic [15:0] marr_val = 16'h0;
  logic [1:0]  incr_sel = 2'd0;
  logic [7:0]  cpu_dout;
  logic        busy;

  int vectors = 0;
  int errors  = 0;

  vdc_read_port_if #(.ADDR_W(16), .DATA_W(16)) vif ();

  vdc_read_port #(.ADDR_W(16), .DATA_W(16)) dut (
    .clock    (clock),
    .reset    (reset),
    .cpu_rd   (cpu_rd),
    .cpu_a    (cpu_a),
    .marr_ld  (marr_ld),
    .marr_val (marr_val),
    .incr_sel (incr_sel),
    .cpu_dout (cpu_dout),
    .busy     (busy),
    .vram     (vif.master)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cpu_read(logic [1:0] a);
    cpu_rd = 1'b1;
    cpu_a  = a;
    tick();
    cpu_rd = 1'b0;
  endtask

  task automatic load_marr(logic [15:0] v);
    marr_ld  = 1'b1;
    marr_val = v;
    tick();
    marr_ld  = 1'b0;
  endtask

  // wait (bounded) for a request, check its address, grant, return data
  task automatic serve(string tag, logic [15:0] exp_addr, logic [15:0] data);
    int n;
    n = 0;
    while (!vif.vram_req && n < 10) begin
      tick();
      n++;
    end
    chk({tag, "_req"}, {31'b0, vif.vram_req}, 32'd1);
    chk({tag, "_addr"}, {16'b0, vif.vram_addr}, {16'b0, exp_addr});
    vif.vram_gnt = 1'b1;
    tick();
    vif.vram_gnt = 1'b0;
    vif.vram_rvalid = 1'b1;
    vif.vram_rdata  = data;
    tick();
    vif.vram_rvalid = 1'b0;
  endtask

  task automatic quiet(string tag);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk({tag, "_noreq"}, {31'b0, vif.vram_req}, 32'd0);
    end
    chk({tag, "_idle"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    vif.vram_gnt    = 1'b0;
    vif.vram_rvalid = 1'b0;
    vif.vram_rdata  = 16'h0;

    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("rst_req", {31'b0, vif.vram_req}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_dout", {24'b0, cpu_dout}, 32'd0);
    chk("rst_addr", {16'b0, vif.vram_addr}, 32'd0);

    // basic fetch with 2-cycle grant delay
    load_marr(16'h1234);
    chk("t1_pend_busy", {31'b0, busy}, 32'd1);
    chk("t1_pend_noreq", {31'b0, vif.vram_req}, 32'd0);
    tick();
    chk("t1_req", {31'b0, vif.vram_req}, 32'd1);
    chk("t1_addr", {16'b0, vif.vram_addr}, 32'h1234);
    tick();
    chk("t1_req_hold", {31'b0, vif.vram_req}, 32'd1);
    vif.vram_gnt = 1'b1;
    tick();
    vif.vram_gnt = 1'b0;
    chk("t1_wait_noreq", {31'b0, vif.vram_req}, 32'd0);
    chk("t1_wait_busy", {31'b0, busy}, 32'd1);
    vif.vram_rvalid = 1'b1;
    vif.vram_rdata  = 16'hBEEF;
    tick();
    vif.vram_rvalid = 1'b0;
    chk("t1_done_busy", {31'b0, busy}, 32'd0);
    cpu_read(2'd2);
    chk("t1_lo", {24'b0, cpu_dout}, 32'hEF);
    incr_sel = 2'd0;
    cpu_read(2'd3);
    chk("t1_hi", {24'b0, cpu_dout}, 32'hBE);
    serve("t1_next", 16'h1235, 16'h5A5A);
    chk("t1_after_busy", {31'b0, busy}, 32'd0);

    // step 32
    load_marr(16'h0010);
    serve("t2_ld", 16'h0010, 16'hA1B2);
    incr_sel = 2'd1;
    cpu_read(2'd3);
    chk("t2_hi", {24'b0, cpu_dout}, 32'hA1);
    serve("t2_inc", 16'h0030, 16'hC3D4);

    // step 128 with wrap
    load_marr(16'hFFF0);
    serve("t3_ld", 16'hFFF0, 16'h1111);
    incr_sel = 2'd3;
    cpu_read(2'd3);
    chk("t3_hi", {24'b0, cpu_dout}, 32'h11);
    serve("t3_wrap", 16'h0070, 16'h2222);

    // marr_ld wins over simultaneous high-byte read
    marr_ld  = 1'b1;
    marr_val = 16'h2000;
    cpu_rd   = 1'b1;
    cpu_a    = 2'd3;
    tick();
    marr_ld  = 1'b0;
    cpu_rd   = 1'b0;
    chk("t4_hi_old", {24'b0, cpu_dout}, 32'h22);
    serve("t4_ld", 16'h2000, 16'h3333);
    quiet("t4");

    // second high-byte read during WAIT
    incr_sel = 2'd0;
    cpu_read(2'd3);
    chk("t5_hi1", {24'b0, cpu_dout}, 32'h33);
    tick();
    chk("t5_req1", {31'b0, vif.vram_req}, 32'd1);
    chk("t5_addr1", {16'b0, vif.vram_addr}, 32'h2001);
    vif.vram_gnt = 1'b1;
    tick();
    vif.vram_gnt = 1'b0;
    cpu_read(2'd3);
    chk("t5_hi2", {24'b0, cpu_dout}, 32'h33);
    cpu_read(2'd0);
    chk("t5_status", {24'b0, cpu_dout}, 32'h80);
    chk("t5_wait_noreq", {31'b0, vif.vram_req}, 32'd0);
    vif.vram_rvalid = 1'b1;
    vif.vram_rdata  = 16'h4444;
    tick();
    vif.vram_rvalid = 1'b0;
    chk("t5_rearm_busy", {31'b0, busy}, 32'd1);
    serve("t5_second", 16'h2002, 16'h5555);
    quiet("t5");
    cpu_read(2'd2);
    chk("t5_lo", {24'b0, cpu_dout}, 32'h55);
    cpu_read(2'd1);
    chk("t5_rsvd", {24'b0, cpu_dout}, 32'h00);

    // reset while in WAIT, then a late rvalid
    load_marr(16'h0100);
    tick();
    chk("t6_req", {31'b0, vif.vram_req}, 32'd1);
    vif.vram_gnt = 1'b1;
    tick();
    vif.vram_gnt = 1'b0;
    reset = 1'b1;
    #1;
    chk("t6_rst_req", {31'b0, vif.vram_req}, 32'd0);
    chk("t6_rst_busy", {31'b0, busy}, 32'd0);
    chk("t6_rst_dout", {24'b0, cpu_dout}, 32'd0);
    tick();
    reset = 1'b0;
    vif.vram_rvalid = 1'b1;
    vif.vram_rdata  = 16'hDEAD;
    tick();
    vif.vram_rvalid = 1'b0;
    chk("t6_late_req", {31'b0, vif.vram_req}, 32'd0);
    chk("t6_late_busy", {31'b0, busy}, 32'd0);
    cpu_read(2'd2);
    chk("t6_latch_lo", {24'b0, cpu_dout}, 32'h00);
    quiet("t6");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
